regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between the ALU writeback

---
 rtl/regfile_wb_arbiter.sv | 125 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: ALU port 0 vs load/mul port 1, with a busy scoreboard.
// Optional REGFILE_WB_BYPASS_EN builds the writeback-to-issue bypass compare.
module regfile_wb_arbiter #(
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic [4:0]    p0_rc,
  input  logic [DW-1:0] p0_data,
  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic [4:0]    p1_rc,
  input  logic [DW-1:0] p1_data,
  input  logic          iss_valid,
  input  logic [4:0]    iss_rc,
  output logic          iss_ready,
  input  logic [4:0]    chk_ra,
  input  logic [4:0]    chk_rb,
  output logic          hazard,
  output logic          wb_werf,
  output logic [4:0]    wb_rc,
  output logic [DW-1:0] wb_wdata,
  output logic          byp_a_hit,
  output logic          byp_b_hit
);

  // state | meaning
  // PRI0  | ALU port has priority; port-1 losses are counted
  // PRI1  | port 1 starved too long, it wins the next request
  typedef enum logic {PRI0, PRI1} state_t;

  localparam logic [4:0] R_ZERO_WB = 5'd31;
  localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

  state_t      state;
  logic [3:0]  starve_cnt;
  logic [31:0] busy;
  logic [31:0] busy_next;
  logic        p0_grant;
  logic        p1_grant;
  logic        iss_fire;

  always_comb begin
    p0_ready = 1'b1;
    p1_ready = 1'b1;
    if (state == PRI0) p1_ready = !p0_valid;
    else               p0_ready = !p1_valid;
  end

  assign p0_grant = p0_valid && p0_ready;
  assign p1_grant = p1_valid && p1_ready;

  assign iss_ready = !busy[iss_rc];
  assign iss_fire  = iss_valid && iss_ready && (iss_rc != R_ZERO_WB);

  // Ordering matters: an issue to the same register overrides the port-1 clear.
  always_comb begin
    busy_next = busy;
    if (p1_grant && p1_rc != R_ZERO_WB) busy_next[p1_rc] = 1'b0;
    if (iss_fire)                       busy_next[iss_rc] = 1'b1;
  end

  assign hazard = (busy[chk_ra] && chk_ra != R_ZERO_WB) ||
                  (busy[chk_rb] && chk_rb != R_ZERO_WB);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= PRI0;
      starve_cnt <= 4'd0;
      busy       <= 32'd0;
      wb_werf    <= 1'b0;
      wb_rc      <= 5'd0;
      wb_wdata   <= '0;
    end else begin
      busy <= busy_next;

      case (state)
        PRI0: begin
          if (p1_grant) begin
            starve_cnt <= 4'd0;
          end else if (p1_valid) begin
            if (starve_cnt == STARVE_LAST) begin
              state      <= PRI1;
              starve_cnt <= 4'd0;
            end else begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        PRI1: begin
          if (p1_grant || !p1_valid) state <= PRI0;
        end
        default: state <= PRI0;
      endcase

      // r31 writes handshake normally but never reach the regfile
      wb_werf <= 1'b0;
      if (p1_grant) begin
        if (p1_rc != R_ZERO_WB) begin
          wb_werf  <= 1'b1;
          wb_rc    <= p1_rc;
          wb_wdata <= p1_data;
        end
      end else if (p0_grant) begin
        if (p0_rc != R_ZERO_WB) begin
          wb_werf  <= 1'b1;
          wb_rc    <= p0_rc;
          wb_wdata <= p0_data;
        end
      end
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  assign byp_a_hit = wb_werf && (wb_rc == chk_ra) && (chk_ra != R_ZERO_WB);
  assign byp_b_hit = wb_werf && (wb_rc == chk_rb) && (chk_rb != R_ZERO_WB);
`else
  assign byp_a_hit = 1'b0;
  assign byp_b_hit = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus pushes expected writes, a monitor pops them.
module tb_regfile_wb_arbiter;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          p0_valid, p1_valid, iss_valid;
  logic          p0_ready, p1_ready, iss_ready, hazard;
  logic [4:0]    p0_rc, p1_rc, iss_rc, chk_ra, chk_rb, wb_rc;
  logic [DW-1:0] p0_data, p1_data, wb_wdata;
  logic          wb_werf, byp_a_hit, byp_b_hit;

  int checks = 0;
  int errors = 0;
  logic [36:0] expq[$];
  logic        byp_exp;

  regfile_wb_arbiter #(.DW(DW), .STARVE_MAX(4)) dut (
    .clock(clock), .reset(reset),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_rc(p0_rc), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_rc(p1_rc), .p1_data(p1_data),
    .iss_valid(iss_valid), .iss_rc(iss_rc), .iss_ready(iss_ready),
    .chk_ra(chk_ra), .chk_rb(chk_rb), .hazard(hazard),
    .wb_werf(wb_werf), .wb_rc(wb_rc), .wb_wdata(wb_wdata),
    .byp_a_hit(byp_a_hit), .byp_b_hit(byp_b_hit)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    @(negedge clock);
    p0_valid = 0; p1_valid = 0; iss_valid = 0;
    #1;
  endtask

  task automatic drive(input logic v0, input logic [4:0] rc0, input logic [DW-1:0] d0,
                       input logic v1, input logic [4:0] rc1, input logic [DW-1:0] d1,
                       input logic iv, input logic [4:0] irc,
                       input logic [4:0] ra, input logic [4:0] rb);
    @(negedge clock);
    p0_valid = v0; p0_rc = rc0; p0_data = d0;
    p1_valid = v1; p1_rc = rc1; p1_data = d1;
    iss_valid = iv; iss_rc = irc; chk_ra = ra; chk_rb = rb;
    #1;
  endtask

  // Monitor: every registered write must match the head of the expected queue.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (!reset && (wb_werf || expq.size() > 0)) begin
        if (expq.size() == 0) begin
          chk("unexpected_write", {27'd0, wb_werf, wb_rc, wb_wdata}, 64'd0);
        end else begin
          logic [36:0] e;
          e = expq.pop_front();
          chk("wb_werf", {63'd0, wb_werf}, 64'd1);
          chk("wb_rc_data", {27'd0, wb_rc, wb_wdata}, {27'd0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef REGFILE_WB_BYPASS_EN
    byp_exp = 1'b1;
`else
    byp_exp = 1'b0;
`endif
    reset = 1; p0_valid = 0; p1_valid = 0; iss_valid = 0;
    p0_rc = 0; p1_rc = 0; iss_rc = 0; chk_ra = 0; chk_rb = 0; p0_data = 0; p1_data = 0;
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    chk("rst_werf", {63'd0, wb_werf}, 64'd0);
    chk("rst_rc_data", {27'd0, wb_rc, wb_wdata}, 64'd0);
    chk("rst_ready", {62'd0, p0_ready, p1_ready}, 64'd3);
    chk("rst_iss_hz", {62'd0, iss_ready, hazard}, 64'd2);
    reset = 0;

    // 1: simple port-0 write
    drive(1, 5'd5, 32'hA5, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_ready", {62'd0, p0_ready, p1_ready}, 64'd2);
    expq.push_back({5'd5, 32'hA5});
    idle();

    // 2: starvation - p0 wins 4 times, p1 on the 5th, then PRI0 again
    for (int i = 0; i < 6; i++) begin
      drive(1, 5'(10 + i), 32'h100 + i, 1, 5'd7, 32'h77, 0, 0, 0, 0);
      if (i == 4) begin
        chk("t2_ready_p1", {62'd0, p0_ready, p1_ready}, 64'd1);
        expq.push_back({5'd7, 32'h77});
      end else begin
        chk("t2_ready_p0", {62'd0, p0_ready, p1_ready}, 64'd2);
        expq.push_back({5'(10 + i), 32'h100 + i});
      end
    end
    idle();

    // 3: scoreboard set by issue, cleared by port-1 writeback
    drive(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0);
    chk("t3_iss_ready_free", {63'd0, iss_ready}, 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd9, 0);
    chk("t3_iss_ready_busy", {63'd0, iss_ready}, 64'd0);
    chk("t3_hazard_set", {63'd0, hazard}, 64'd1);
    drive(0, 0, 0, 1, 5'd9, 32'h99, 0, 5'd9, 5'd9, 0);
    chk("t3_p1_ready", {63'd0, p1_ready}, 64'd1);
    chk("t3_hazard_hold", {63'd0, hazard}, 64'd1);
    expq.push_back({5'd9, 32'h99});
    drive(0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd9, 0);
    chk("t3_hazard_drop", {62'd0, wb_werf, hazard}, 64'd2);
    chk("t3_iss_ready_back", {63'd0, iss_ready}, 64'd1);

    // 4: same-cycle set and clear of r3, set wins
    drive(0, 0, 0, 1, 5'd3, 32'h33, 1, 5'd3, 0, 0);
    expq.push_back({5'd3, 32'h33});
    drive(0, 0, 0, 0, 0, 0, 0, 5'd3, 0, 5'd3);
    chk("t4_iss_ready", {63'd0, iss_ready}, 64'd0);
    chk("t4_hazard_rb", {63'd0, hazard}, 64'd1);
    drive(0, 0, 0, 1, 5'd3, 32'h34, 0, 5'd3, 0, 5'd3);
    expq.push_back({5'd3, 32'h34});
    drive(0, 0, 0, 0, 0, 0, 0, 5'd3, 0, 5'd3);
    chk("t4_hazard_clear", {63'd0, hazard}, 64'd0);

    // 5: r31 handshakes but never writes or becomes busy
    drive(1, 5'd31, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_p0_ready", {63'd0, p0_ready}, 64'd1);
    drive(0, 0, 0, 0, 0, 0, 1, 5'd31, 0, 0);
    chk("t5_werf_r31", {63'd0, wb_werf}, 64'd0);
    chk("t5_iss_ready31", {63'd0, iss_ready}, 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 5'd31, 5'd31, 5'd31);
    chk("t5_hazard31", {62'd0, iss_ready, hazard}, 64'd2);

    // 6: bypass hit in the writeback cycle only
    drive(1, 5'd12, 32'hC12, 0, 0, 0, 0, 0, 0, 0);
    expq.push_back({5'd12, 32'hC12});
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd12);
    chk("t6_byp_b", {62'd0, byp_a_hit, byp_b_hit}, {63'd0, byp_exp});
    drive(0, 0, 0, 0, 0, 0, 0, 0, 5'd12, 5'd12);
    chk("t6_byp_after", {62'd0, byp_a_hit, byp_b_hit}, 64'd0);

    // reset mid-stream discards the pending grant and clears busy
    drive(1, 5'd14, 32'h14, 0, 0, 0, 1, 5'd20, 0, 0);
    expq.push_back({5'd14, 32'h14});
    drive(1, 5'd15, 32'h15, 0, 0, 0, 0, 5'd20, 5'd20, 0);
    chk("rst_mid_hazard_before", {63'd0, hazard}, 64'd1);
    reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0, 5'd20, 5'd20, 0);
    chk("rst_mid_werf", {63'd0, wb_werf}, 64'd0);
    chk("rst_mid_busy", {62'd0, iss_ready, hazard}, 64'd2);
    chk("rst_mid_rc", {59'd0, wb_rc}, 64'd0);
    reset = 0;

    idle();
    idle();
    chk("queue_drained", 64'(expq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
